calc_hist: RTL and testbench
============================

# calc_hist

Parametrised accumulator calculator with synchronised, edge-detected buttons, an 8-operation signed datapath, overflow/zero flags and a DEPTH-entry undo history. It is the next-generation top-level calculator for the board. Switches provide operand B, LEDs show the accumulator, and every committed result can be rolled back through a circular history buffer.

## Interface
- WIDTH, 16, datapath/accumulator width; power of 2, ≥4; SHW = $clog2(WIDTH).
- DEPTH, 4, undo history entries; power of 2, ≥2.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btnc  input  1  opcode bit 1 (level, raw).
- btnl  input  1  opcode bit 2 (level, raw).
- btnr  input  1  opcode bit 0 (level, raw).
- btnu  input  1  clear request (raw, rising-edge triggered).
- btnd  input  1  commit request (raw, rising-edge triggered).
- undo  input  1  undo request (raw, rising-edge triggered).
- sw  input  WIDTH  operand B, signed.
- led  output  WIDTH  accumulator value.
- ovf  output  1  overflow of last committed operation.
- zero  output  1  high when accumulator == 0.
- hist_cnt  output  $clog2(DEPTH+1)  valid history entries, 0..DEPTH.

## Operation
- Reset (async assert, any time, including mid-press): acc=0, ovf=0, hist_cnt=0, write pointer=0, all synchroniser and edge flops=0. Outputs: led=0, ovf=0, zero=1, hist_cnt=0.
- btnu, btnd and undo each pass through a 2-flop synchroniser, then a rising-edge detector. The result is a one-cycle pulse per press. A held button produces exactly one pulse.
- op = {btnl, btnc, btnr}, sampled unsynchronised at the commit edge. op and sw must be stable while btnd is pressed.
- Operations, A = acc, B = sw, both signed WIDTH bits, result truncated to WIDTH:
  - 000 ADD. ovf = signed overflow.
  - 001 SUB (A−B). ovf = signed overflow.
  - 010 AND. ovf = 0.
  - 011 OR. ovf = 0.
  - 100 XOR. ovf = 0.
  - 101 LSL by B[SHW-1:0]. ovf = 0.
  - 110 ASR by B[SHW-1:0]. ovf = 0.
  - 111 MUL, low WIDTH bits of the 2·WIDTH signed product. ovf = 1 if the full product ≠ sign-extension of its low WIDTH bits.
- Commit pulse:
  - Push old acc into history at the write pointer, then increment the pointer mod DEPTH.
  - hist_cnt = min(hist_cnt+1, DEPTH). When full, the oldest entry is overwritten (circular).
  - acc ← result; ovf updated as above.
- Undo pulse:
  - If hist_cnt > 0: decrement the pointer mod DEPTH, acc ← history[pointer], hist_cnt−1, ovf ← 0.
  - If hist_cnt == 0: no state change.
- Clear pulse: acc=0, ovf=0, hist_cnt=0, pointer=0. History contents are not zeroed but are unreachable.
- Simultaneous pulses in one cycle: clear > undo > commit. Only the highest-priority pulse acts; the others are dropped.
- zero is combinational from the acc register. led = acc directly.

## Timing
- A raw button first sampled high at edge k: sync stage 2 is high after edge k+1, the pulse is active during cycle k+1→k+2, and acc/ovf/hist_cnt update at edge k+2.
- Latency is 2 clock edges from first-high sample to visible result. Throughput is one operation per press; a new press needs at least one low sample in the synchroniser.
- No combinational path from any input to any output.

## Test plan
- Reset: assert rst_n=0 mid-run with acc=0x1234 -> immediately led=0x0000, ovf=0, zero=1, hist_cnt=0.
- Overflow: commit ADD sw=0x7FFF, then ADD sw=0x0001 -> led=0x8000, ovf=1, hist_cnt=2. Commit SUB sw=0x0001 -> led=0x7FFF, ovf=1.
- Shift/MUL:
  - acc=0x8000, ASR sw=4 -> 0xF800.
  - acc=0x0100, MUL sw=0x0100 -> 0x0000, ovf=1.
  - acc=0x0003, MUL sw=0xFFFE -> 0xFFFA, ovf=0.
- History wrap: from 0, five ADD sw=1 commits -> acc=5, hist_cnt=4. Four undos -> acc=1, hist_cnt=0. Fifth undo -> acc stays 1.
- Edge/latency: hold btnd high for 10 cycles with ADD sw=2 -> acc increments once, at edge k+2, hist_cnt+1 only.
- Priority: btnu, undo and btnd rise in the same cycle with acc=7, hist_cnt=3 -> acc=0, hist_cnt=0, ovf=0. Then undo -> no change.

Source files
------------

// File: rtl/calc_hist.sv
// calc_hist: accumulator calculator with synchronised, edge-detected buttons,
// an 8-operation signed datapath, overflow/zero flags and a circular undo history.
module calc_hist #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btnc,
  input  logic                         btnl,
  input  logic                         btnr,
  input  logic                         btnu,
  input  logic                         btnd,
  input  logic                         undo,
  input  logic [WIDTH-1:0]             sw,
  output logic [WIDTH-1:0]             led,
  output logic                         ovf,
  output logic                         zero,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH+1);

  // Button lanes: 0 = clear (btnu), 1 = commit (btnd), 2 = undo
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [2:0]         r_prev;
  logic [2:0]         w_pulse;

  logic [WIDTH-1:0]   r_acc;
  logic               r_ovf;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_wptr;
  logic [WIDTH-1:0]   r_hist [DEPTH];

  logic [2:0]         w_op;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_result;
  logic               w_res_ovf;

  logic [WIDTH-1:0]   w_acc_nxt;
  logic               w_ovf_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [PW-1:0]      w_wptr_nxt;
  logic [PW-1:0]      w_wptr_dec;
  logic               w_hist_we;

  // Two-flop synchroniser followed by a previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {undo, btnd, btnu};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_pulse = r_sync2 & ~r_prev;

  // Signed ALU: result and overflow flag for the selected operation
  always_comb begin
    w_op      = {btnl, btnc, btnr};
    w_shamt   = sw[SHW-1:0];
    w_sum     = r_acc + sw;
    w_diff    = r_acc - sw;
    w_a_ext   = {{WIDTH{r_acc[WIDTH-1]}}, r_acc};
    w_b_ext   = {{WIDTH{sw[WIDTH-1]}}, sw};
    w_prod    = w_a_ext * w_b_ext;
    w_result  = '0;
    w_res_ovf = 1'b0;
    case (w_op)
      3'b000: begin
        w_result  = w_sum;
        w_res_ovf = (r_acc[WIDTH-1] == sw[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
      end
      3'b001: begin
        w_result  = w_diff;
        w_res_ovf = (r_acc[WIDTH-1] != sw[WIDTH-1]) && (w_diff[WIDTH-1] != r_acc[WIDTH-1]);
      end
      3'b010: w_result = r_acc & sw;
      3'b011: w_result = r_acc | sw;
      3'b100: w_result = r_acc ^ sw;
      3'b101: w_result = r_acc << w_shamt;
      3'b110: w_result = WIDTH'($signed(r_acc) >>> w_shamt);
      3'b111: begin
        w_result  = w_prod[WIDTH-1:0];
        w_res_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
      end
      default: begin
        w_result  = '0;
        w_res_ovf = 1'b0;
      end
    endcase
  end

  // Next-state selection with priority clear > undo > commit
  always_comb begin
    w_acc_nxt  = r_acc;
    w_ovf_nxt  = r_ovf;
    w_cnt_nxt  = r_cnt;
    w_wptr_nxt = r_wptr;
    w_hist_we  = 1'b0;
    w_wptr_dec = r_wptr - PW'(1);
    if (w_pulse[0]) begin
      w_acc_nxt  = '0;
      w_ovf_nxt  = 1'b0;
      w_cnt_nxt  = '0;
      w_wptr_nxt = '0;
    end else if (w_pulse[2]) begin
      if (r_cnt != '0) begin
        w_wptr_nxt = w_wptr_dec;
        w_acc_nxt  = r_hist[w_wptr_dec];
        w_cnt_nxt  = r_cnt - CW'(1);
        w_ovf_nxt  = 1'b0;
      end
    end else if (w_pulse[1]) begin
      w_hist_we  = 1'b1;
      w_wptr_nxt = r_wptr + PW'(1);
      w_cnt_nxt  = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + CW'(1);
      w_acc_nxt  = w_result;
      w_ovf_nxt  = w_res_ovf;
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      r_wptr <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_ovf  <= w_ovf_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wptr <= w_wptr_nxt;
    end
  end

  // History storage; contents need no reset since r_cnt gates reachability
  always_ff @(posedge clk) begin
    if (w_hist_we) r_hist[r_wptr] <= r_acc;
  end

  assign led      = r_acc;
  assign ovf      = r_ovf;
  assign zero     = (r_acc == '0);
  assign hist_cnt = r_cnt;

endmodule

// File: tb/tb_calc_hist.sv
// Self-checking bench for calc_hist: directed scenarios plus randomized
// operations against a queue-based behavioural model.
module tb_calc_hist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btnc, btnl, btnr, btnu, btnd, undo;
  logic [15:0] sw;
  logic [15:0] led;
  logic        ovf, zero;
  logic [2:0]  hist_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: accumulator, flag and a bounded history queue
  logic [15:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_hist[$];

  calc_hist #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .btnc(btnc), .btnl(btnl), .btnr(btnr),
    .btnu(btnu), .btnd(btnd), .undo(undo), .sw(sw),
    .led(led), .ovf(ovf), .zero(zero), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_commit(input logic [2:0] op, input logic [15:0] b);
    int     sa, sb, s;
    longint p;
    sa = int'($signed(m_acc));
    sb = int'($signed(b));
    m_hist.push_back(m_acc);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    m_ovf = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; m_ovf = (s > 32767) || (s < -32768); m_acc = 16'(s); end
      3'd1: begin s = sa - sb; m_ovf = (s > 32767) || (s < -32768); m_acc = 16'(s); end
      3'd2: m_acc = m_acc & b;
      3'd3: m_acc = m_acc | b;
      3'd4: m_acc = m_acc ^ b;
      3'd5: m_acc = 16'(m_acc << b[3:0]);
      3'd6: m_acc = 16'(sa >>> b[3:0]);
      default: begin
        p = longint'(sa) * longint'(sb);
        m_ovf = (p > 32767) || (p < -32768);
        m_acc = 16'(p);
      end
    endcase
  endfunction

  function automatic void model_undo();
    if (m_hist.size() > 0) begin
      m_acc = m_hist.pop_back();
      m_ovf = 1'b0;
    end
  endfunction

  function automatic void model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_hist.delete();
  endfunction

  // Hold a button for three cycles, release, then let the synchroniser drain
  task automatic press_commit(input logic [2:0] op, input logic [15:0] b);
    @(negedge clk);
    {btnl, btnc, btnr} = op;
    sw   = b;
    btnd = 1'b1;
    repeat (3) @(negedge clk);
    btnd = 1'b0;
    repeat (3) @(negedge clk);
    model_commit(op, b);
  endtask

  task automatic press_undo();
    @(negedge clk);
    undo = 1'b1;
    repeat (3) @(negedge clk);
    undo = 1'b0;
    repeat (3) @(negedge clk);
    model_undo();
  endtask

  task automatic press_clear();
    @(negedge clk);
    btnu = 1'b1;
    repeat (3) @(negedge clk);
    btnu = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset();
    n_total++;
    if ({led, ovf, zero, hist_cnt} !== {16'h0000, 1'b0, 1'b1, 3'd0})
      $display("FAIL reset_init: {led,ovf,zero,cnt} got %h want %h",
               {led, ovf, zero, hist_cnt}, {16'h0000, 1'b0, 1'b1, 3'd0});
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    press_clear();
    press_commit(3'd0, 16'h1234);
    n_total++;
    if ({led, hist_cnt} !== {16'h1234, 3'd1})
      $display("FAIL reset_setup: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h1234, 3'd1});
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({led, ovf, zero, hist_cnt} !== {16'h0000, 1'b0, 1'b1, 3'd0})
      $display("FAIL reset_async: {led,ovf,zero,cnt} got %h want %h",
               {led, ovf, zero, hist_cnt}, {16'h0000, 1'b0, 1'b1, 3'd0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow();
    press_clear();
    press_commit(3'd0, 16'h7FFF);
    press_commit(3'd0, 16'h0001);
    n_total++;
    if ({led, ovf, zero, hist_cnt} !== {16'h8000, 1'b1, 1'b0, 3'd2})
      $display("FAIL ovf_add: {led,ovf,zero,cnt} got %h want %h",
               {led, ovf, zero, hist_cnt}, {16'h8000, 1'b1, 1'b0, 3'd2});
    else n_pass++;
    press_commit(3'd1, 16'h0001);
    n_total++;
    if ({led, ovf} !== {16'h7FFF, 1'b1})
      $display("FAIL ovf_sub: {led,ovf} got %h want %h", {led, ovf}, {16'h7FFF, 1'b1});
    else n_pass++;
  endtask

  task automatic test_shift_mul();
    press_clear();
    press_commit(3'd0, 16'h8000);
    press_commit(3'd6, 16'h0004);
    n_total++;
    if ({led, ovf} !== {16'hF800, 1'b0})
      $display("FAIL asr: {led,ovf} got %h want %h", {led, ovf}, {16'hF800, 1'b0});
    else n_pass++;
    press_clear();
    press_commit(3'd0, 16'h0100);
    press_commit(3'd7, 16'h0100);
    n_total++;
    if ({led, ovf, zero} !== {16'h0000, 1'b1, 1'b1})
      $display("FAIL mul_ovf: {led,ovf,zero} got %h want %h", {led, ovf, zero}, {16'h0000, 1'b1, 1'b1});
    else n_pass++;
    press_clear();
    press_commit(3'd0, 16'h0003);
    press_commit(3'd7, 16'hFFFE);
    n_total++;
    if ({led, ovf} !== {16'hFFFA, 1'b0})
      $display("FAIL mul_neg: {led,ovf} got %h want %h", {led, ovf}, {16'hFFFA, 1'b0});
    else n_pass++;
  endtask

  task automatic test_hist_wrap();
    press_clear();
    for (int i = 0; i < 5; i++) press_commit(3'd0, 16'h0001);
    n_total++;
    if ({led, hist_cnt} !== {16'h0005, 3'd4})
      $display("FAIL wrap_fill: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h0005, 3'd4});
    else n_pass++;
    for (int i = 0; i < 4; i++) press_undo();
    n_total++;
    if ({led, ovf, hist_cnt} !== {16'h0001, 1'b0, 3'd0})
      $display("FAIL wrap_undo: {led,ovf,cnt} got %h want %h", {led, ovf, hist_cnt}, {16'h0001, 1'b0, 3'd0});
    else n_pass++;
    press_undo();
    n_total++;
    if ({led, hist_cnt} !== {16'h0001, 3'd0})
      $display("FAIL wrap_empty: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h0001, 3'd0});
    else n_pass++;
  endtask

  task automatic test_edge_latency();
    press_clear();
    @(negedge clk);
    {btnl, btnc, btnr} = 3'd0;
    sw   = 16'h0002;
    btnd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({led, hist_cnt} !== {16'h0000, 3'd0})
      $display("FAIL latency_early: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h0000, 3'd0});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({led, hist_cnt} !== {16'h0002, 3'd1})
      $display("FAIL latency_k2: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h0002, 3'd1});
    else n_pass++;
    repeat (7) @(negedge clk);
    n_total++;
    if ({led, hist_cnt} !== {16'h0002, 3'd1})
      $display("FAIL held_once: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h0002, 3'd1});
    else n_pass++;
    btnd = 1'b0;
    repeat (3) @(negedge clk);
    model_commit(3'd0, 16'h0002);
  endtask

  task automatic test_priority();
    press_clear();
    press_commit(3'd0, 16'h0001);
    press_commit(3'd0, 16'h0002);
    press_commit(3'd0, 16'h0004);
    n_total++;
    if ({led, hist_cnt} !== {16'h0007, 3'd3})
      $display("FAIL prio_setup: {led,cnt} got %h want %h", {led, hist_cnt}, {16'h0007, 3'd3});
    else n_pass++;
    @(negedge clk);
    {btnl, btnc, btnr} = 3'd0;
    sw   = 16'h0005;
    btnu = 1'b1;
    undo = 1'b1;
    btnd = 1'b1;
    repeat (3) @(negedge clk);
    {btnu, undo, btnd} = 3'b000;
    repeat (3) @(negedge clk);
    model_clear();
    n_total++;
    if ({led, ovf, zero, hist_cnt} !== {16'h0000, 1'b0, 1'b1, 3'd0})
      $display("FAIL prio_clear: {led,ovf,zero,cnt} got %h want %h",
               {led, ovf, zero, hist_cnt}, {16'h0000, 1'b0, 1'b1, 3'd0});
    else n_pass++;
    press_undo();
    n_total++;
    if ({led, ovf, hist_cnt} !== {16'h0000, 1'b0, 3'd0})
      $display("FAIL prio_undo: {led,ovf,cnt} got %h want %h", {led, ovf, hist_cnt}, {16'h0000, 1'b0, 3'd0});
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned kind;
    logic [2:0]  op;
    logic [15:0] b;
    press_clear();
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 99);
      if (kind < 4) press_clear();
      else if (kind < 25) press_undo();
      else begin
        op = 3'($urandom_range(0, 7));
        b  = 16'($urandom);
        if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
        press_commit(op, b);
      end
      n_total++;
      if ({led, ovf, zero, hist_cnt} !== {m_acc, m_ovf, (m_acc == 16'h0), 3'(m_hist.size())})
        $display("FAIL random[%0d]: {led,ovf,zero,cnt} got %h want %h", i,
                 {led, ovf, zero, hist_cnt}, {m_acc, m_ovf, (m_acc == 16'h0), 3'(m_hist.size())});
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {btnc, btnl, btnr, btnu, btnd, undo} = 6'b0;
    sw = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_overflow();
    test_shift_mul();
    test_hist_wrap();
    test_edge_latency();
    test_priority();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
